// File: rtl/btc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btc_pkg
// Description : Shared constants, state encoding and helpers for the
//               header word server.
// Revision    : 1.0 - initial release
// ============================================================================
package btc_pkg;

    localparam int HDR_BYTES  = 80;
    localparam int HDR_WORDS  = HDR_BYTES / 4;
    localparam int NONCE_WORD = 19;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD = 32'(HDR_BYTES * 8);

    // Word addresses of the padding-block entries that are not header data
    localparam logic [4:0] PAD_ADDR = 5'(HDR_WORDS);
    localparam logic [4:0] LEN_ADDR = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    // Reverse byte order; the nonce is little-endian inside a big-endian word
    function automatic logic [31:0] byteswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/header_word_server_if.sv
`default_nettype none
// ============================================================================
// Module      : header_word_server_if
// Description : Byte-load, nonce and word-request signals of the header
//               word server. master = feeder/hasher side, slave = server.
// Revision    : 1.0 - initial release
// ============================================================================
interface header_word_server_if;

    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        hdr_valid;
    logic        nonce_inc;
    logic        nonce_wrap;
    logic        w_rq;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        w_rdy;

    modport master (
        output load_start, in_valid, in_data, nonce_inc, w_rq, w_addr,
        input  in_ready, hdr_valid, nonce_wrap, w_data, w_rdy
    );

    modport slave (
        input  load_start, in_valid, in_data, nonce_inc, w_rq, w_addr,
        output in_ready, hdr_valid, nonce_wrap, w_data, w_rdy
    );

endinterface
`default_nettype wire

// File: rtl/header_regfile.sv
`default_nettype none
// ============================================================================
// Module      : header_regfile
// Description : Header storage (HDR_WORDS x 32). Byte write port, word read
//               port and an in-place little-endian nonce increment port.
// Revision    : 1.0 - initial release
// ============================================================================
module header_regfile
    import btc_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        wr_en_i,
    input  wire logic [6:0]  wr_addr_i,
    input  wire logic [7:0]  wr_data_i,
    input  wire logic [4:0]  rd_addr_i,
    output logic      [31:0] rd_data_o,
    input  wire logic        inc_en_i,
    output logic             inc_carry_o
);

    // Storage is deliberately not reset: a reset must not cost a header reload
    logic [31:0] mem_q [HDR_WORDS];

    logic [4:0]  w_wr_word;
    logic [1:0]  w_wr_lane;
    logic        w_wr_ok;
    logic [32:0] w_nonce_sum;

    assign w_wr_word = wr_addr_i[6:2];
    assign w_wr_lane = wr_addr_i[1:0];
    assign w_wr_ok   = wr_en_i && (wr_addr_i < 7'(HDR_BYTES));

    // Nonce value is the byte-swapped word; the 33rd bit is the wrap carry
    assign w_nonce_sum = {1'b0, byteswap32(mem_q[NONCE_WORD])} + 33'd1;
    assign inc_carry_o = w_nonce_sum[32];

    // Combinational word read; out-of-range addresses return zero
    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i < 5'(HDR_WORDS)) begin
            rd_data_o = mem_q[rd_addr_i];
        end
    end

    // Write port: nonce write-back or a single header byte (never both at once)
    always_ff @(posedge clk) begin
        if (inc_en_i) begin
            mem_q[NONCE_WORD] <= byteswap32(w_nonce_sum[31:0]);
        end else if (w_wr_ok) begin
            // Byte 4k sits in bits [31:24] of word k
            case (w_wr_lane)
                2'd0:    mem_q[w_wr_word][31:24] <= wr_data_i;
                2'd1:    mem_q[w_wr_word][23:16] <= wr_data_i;
                2'd2:    mem_q[w_wr_word][15:8]  <= wr_data_i;
                default: mem_q[w_wr_word][7:0]   <= wr_data_i;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/header_word_server.sv
`default_nettype none
// ============================================================================
// Module      : header_word_server
// Description : Loads an 80-byte block header from a byte stream and serves
//               the 32 words of the two SHA-256 message blocks (header plus
//               padding) to the hasher. Owns and increments the nonce.
// Revision    : 1.0 - initial release
// ============================================================================
module header_word_server
    import btc_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    header_word_server_if.slave bus
);

    localparam logic [6:0] C_LAST_BYTE = 7'(HDR_BYTES - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        w_rdy_q;
    logic [31:0] w_data_q;
    logic        nonce_wrap_q;

    logic        w_byte_acc;
    logic        w_nonce_acc;
    logic        w_req_acc;
    logic        w_carry;
    logic [31:0] w_rd_data;
    logic [31:0] w_word;
    logic        w_in_ready;
    logic        w_hdr_valid;

    // load_start wins over a byte or a nonce increment in the same cycle
    assign w_byte_acc  = (state_q == S_LOAD)  && bus.in_valid  && !bus.load_start;
    assign w_nonce_acc = (state_q == S_READY) && bus.nonce_inc && !bus.load_start;
    // One accept per two cycles: never accept while the previous answer is out
    assign w_req_acc   = (state_q == S_READY) && bus.w_rq && !w_rdy_q;

    header_regfile u_regfile (
        .clk         (clk),
        .wr_en_i     (w_byte_acc),
        .wr_addr_i   (cnt_q),
        .wr_data_i   (bus.in_data),
        .rd_addr_i   (bus.w_addr),
        .rd_data_o   (w_rd_data),
        .inc_en_i    (w_nonce_acc),
        .inc_carry_o (w_carry)
    );

    // Word map: header words, then the padding block constants
    always_comb begin
        w_word = '0;
        if (bus.w_addr < PAD_ADDR) begin
            w_word = w_rd_data;
        end else if (bus.w_addr == PAD_ADDR) begin
            w_word = PAD_WORD;
        end else if (bus.w_addr == LEN_ADDR) begin
            w_word = LEN_WORD;
        end
    end

    // State and byte-count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_in_ready  = 1'b0;
        w_hdr_valid = 1'b0;
        case (state_q)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (w_byte_acc) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == C_LAST_BYTE) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                w_hdr_valid = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.load_start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
        end
    end

    // Word response and nonce-wrap pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_rdy_q      <= 1'b0;
            w_data_q     <= '0;
            nonce_wrap_q <= 1'b0;
        end else begin
            w_rdy_q      <= w_req_acc;
            nonce_wrap_q <= w_nonce_acc && w_carry;
            if (w_req_acc) begin
                w_data_q <= w_word;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.hdr_valid  = w_hdr_valid;
    assign bus.w_rdy      = w_rdy_q;
    assign bus.w_data     = w_data_q;
    assign bus.nonce_wrap = nonce_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_header_word_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_header_word_server
// Description : Directed self-checking bench for header_word_server.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_header_word_server;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [7:0] hdr [80];

    header_word_server_if bus ();

    header_word_server dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int a);
        if (a < 20) return {hdr[4*a], hdr[4*a+1], hdr[4*a+2], hdr[4*a+3]};
        if (a == 20) return 32'h8000_0000;
        if (a == 31) return 32'h0000_0280;
        return 32'h0;
    endfunction

    // Optionally pulse load_start, then stream hdr[0..n-1]
    task automatic load_bytes(input int n, input bit start);
        if (start) begin
            bus.load_start = 1'b1;
            tick();
            bus.load_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = hdr[i];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // Issue one request and wait (bounded) for w_rdy
    task automatic do_req(input logic [4:0] a, output logic [31:0] d, output int lat);
        bus.w_rq   = 1'b1;
        bus.w_addr = a;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.w_rdy && lat < 8);
        d = bus.w_data;
        bus.w_rq = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.in_ready !== 1'b0 || bus.hdr_valid !== 1'b0 || bus.w_rdy !== 1'b0
            || bus.w_data !== 32'h0 || bus.nonce_wrap !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b hv=%b wr=%b wd=%h nw=%b, want all 0",
                     bus.in_ready, bus.hdr_valid, bus.w_rdy, bus.w_data, bus.nonce_wrap);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [4:0]  addrs [5];
        logic [31:0] exps  [5];
        logic [31:0] d;
        int          lat;
        addrs = '{5'd0, 5'd19, 5'd20, 5'd25, 5'd31};
        exps  = '{32'h00010203, 32'h4C4D4E4F, 32'h80000000, 32'h00000000, 32'h00000280};
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        load_bytes(80, 1'b1);
        tests++;
        if (bus.hdr_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_done: hdr_valid=%b in_ready=%b, want 1/0", bus.hdr_valid, bus.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            do_req(addrs[i], d, lat);
            tests++;
            if (d !== exps[i] || lat !== 1) begin
                fails++;
                $display("FAIL basic_addr%0d: data=%h lat=%0d, want %h lat=1", addrs[i], d, lat, exps[i]);
            end
            tests++;
            if (bus.w_rdy !== 1'b0) begin
                fails++;
                $display("FAIL basic_rdy_pulse%0d: w_rdy=%b two cycles after accept, want 0", addrs[i], bus.w_rdy);
            end
        end
    endtask

    task automatic test_nonce_wrap();
        logic [31:0] d;
        int          lat;
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        for (int i = 76; i < 80; i++) hdr[i] = 8'hFF;
        load_bytes(80, 1'b1);
        bus.nonce_inc = 1'b1;
        tick();
        bus.nonce_inc = 1'b0;
        tests++;
        if (bus.nonce_wrap !== 1'b1) begin
            fails++;
            $display("FAIL nonce_wrap_pulse: nonce_wrap=%b, want 1", bus.nonce_wrap);
        end
        tick();
        tests++;
        if (bus.nonce_wrap !== 1'b0) begin
            fails++;
            $display("FAIL nonce_wrap_width: nonce_wrap=%b a cycle later, want 0", bus.nonce_wrap);
        end
        do_req(5'd19, d, lat);
        tests++;
        if (d !== 32'h00000000 || lat !== 1) begin
            fails++;
            $display("FAIL nonce_wrap_word: data=%h lat=%0d, want 00000000 lat=1", d, lat);
        end
    endtask

    task automatic test_nonce_inc();
        logic [31:0] d;
        int          lat;
        hdr[76] = 8'h01; hdr[77] = 8'h00; hdr[78] = 8'h00; hdr[79] = 8'h00;
        load_bytes(80, 1'b1);
        bus.nonce_inc = 1'b1;
        tick();
        bus.nonce_inc = 1'b0;
        tests++;
        if (bus.nonce_wrap !== 1'b0) begin
            fails++;
            $display("FAIL nonce_nowrap: nonce_wrap=%b, want 0", bus.nonce_wrap);
        end
        do_req(5'd19, d, lat);
        tests++;
        if (d !== 32'h02000000) begin
            fails++;
            $display("FAIL nonce_inc_word: data=%h, want 02000000", d);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i * 7 + 3);
        load_bytes(80, 1'b1);
        bus.w_rq = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.w_addr = 5'(a);
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!bus.w_rdy && cyc < 8);
            tests++;
            if (bus.w_data !== exp_word(a) || bus.w_rdy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_data%0d: data=%h rdy=%b, want %h rdy=1", a, bus.w_data, bus.w_rdy, exp_word(a));
            end
            tests++;
            if (cyc !== ((a == 0) ? 1 : 2)) begin
                fails++;
                $display("FAIL b2b_spacing%0d: %0d cycles, want %0d", a, cyc, (a == 0) ? 1 : 2);
            end
        end
        bus.w_rq = 1'b0;
        tick();
    endtask

    task automatic test_rq_during_load();
        int early;
        early = 0;
        for (int i = 0; i < 80; i++) hdr[i] = 8'(255 - i);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.w_rq   = 1'b1;
        bus.w_addr = 5'd5;
        for (int i = 0; i < 80; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = hdr[i];
            tick();
            if (bus.w_rdy !== 1'b0) early++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL rq_load_early: w_rdy seen %0d times during load, want 0", early);
        end
        tick();
        tests++;
        if (bus.w_rdy !== 1'b1 || bus.w_data !== 32'hEBEAE9E8) begin
            fails++;
            $display("FAIL rq_load_serve: rdy=%b data=%h, want 1 EBEAE9E8", bus.w_rdy, bus.w_data);
        end
        bus.w_rq = 1'b0;
        tick();
    endtask

    task automatic test_restart();
        logic [31:0] d;
        int          lat;
        for (int i = 0; i < 80; i++) hdr[i] = 8'h11;
        load_bytes(40, 1'b1);
        tests++;
        if (bus.hdr_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL restart_partial: hdr_valid=%b in_ready=%b, want 0/1", bus.hdr_valid, bus.in_ready);
        end
        for (int i = 0; i < 80; i++) hdr[i] = 8'(8'h80 + i);
        load_bytes(80, 1'b1);
        do_req(5'd0, d, lat);
        tests++;
        if (d !== 32'h80818283) begin
            fails++;
            $display("FAIL restart_w0: data=%h, want 80818283", d);
        end
        do_req(5'd9, d, lat);
        tests++;
        if (d !== 32'hA4A5A6A7) begin
            fails++;
            $display("FAIL restart_w9: data=%h, want A4A5A6A7", d);
        end
        do_req(5'd19, d, lat);
        tests++;
        if (d !== 32'hCCCDCECF) begin
            fails++;
            $display("FAIL restart_w19: data=%h, want CCCDCECF", d);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        load_bytes(30, 1'b1);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0 || bus.hdr_valid !== 1'b0 || bus.w_rdy !== 1'b0) begin
            fails++;
            $display("FAIL rst_midload: in_ready=%b hdr_valid=%b w_rdy=%b, want 0",
                     bus.in_ready, bus.hdr_valid, bus.w_rdy);
        end
        rst = 1'b0;
        tick();
        load_bytes(80, 1'b1);
        bus.w_rq   = 1'b1;
        bus.w_addr = 5'd1;
        tick();
        bus.w_rq = 1'b0;
        tests++;
        if (bus.w_rdy !== 1'b1 || bus.w_data !== 32'h04050607) begin
            fails++;
            $display("FAIL rst_serve_pre: rdy=%b data=%h, want 1 04050607", bus.w_rdy, bus.w_data);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.w_rdy !== 1'b0 || bus.w_data !== 32'h0 || bus.hdr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_midserve: rdy=%b data=%h hdr_valid=%b, want 0 00000000 0",
                     bus.w_rdy, bus.w_data, bus.hdr_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        int          lat;
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        hdr[76] = 8'h10; hdr[77] = 8'h20; hdr[78] = 8'h30; hdr[79] = 8'h40;
        load_bytes(80, 1'b1);
        bus.w_rq      = 1'b1;
        bus.w_addr    = 5'd19;
        bus.nonce_inc = 1'b1;
        tick();
        bus.w_rq      = 1'b0;
        bus.nonce_inc = 1'b0;
        tests++;
        if (bus.w_rdy !== 1'b1 || bus.w_data !== 32'h10203040) begin
            fails++;
            $display("FAIL simul_old: rdy=%b data=%h, want 1 10203040", bus.w_rdy, bus.w_data);
        end
        tick();
        do_req(5'd19, d, lat);
        tests++;
        if (d !== 32'h11203040) begin
            fails++;
            $display("FAIL simul_new: data=%h, want 11203040", d);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.nonce_inc  = 1'b0;
        bus.w_rq       = 1'b0;
        bus.w_addr     = 5'd0;
        test_reset();
        test_basic();
        test_nonce_wrap();
        test_nonce_inc();
        test_back_to_back();
        test_rq_during_load();
        test_restart();
        test_rst_mid();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/header_word_server.md
Name: header_word_server

Overview:
- Upstream feeder for the sha256d_wrapper core.
- Accepts an 80-byte block header as a byte stream from the external pin interface and stores it.
- Answers the hasher's word requests (addr 0..31) with 32-bit words, including both SHA-256 padding blocks.
- Owns the nonce field and can increment it in place, so repeated hashing needs no header reload.

Parameters:
- HDR_BYTES, 80, header length in bytes; must be a multiple of 4 and ≤ 119. Fixed at 80 in the top level.
- NONCE_WORD, 19, word index holding the little-endian nonce.
- LEN_BITS, HDR_BYTES*8 (640 = 0x280), message length written into the last padding word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse; (re)starts header loading
- in_valid  in  1  byte-stream valid
- in_data  in  8  header byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- hdr_valid  out  1  complete header stored
- nonce_inc  in  1  pulse; nonce += 1
- nonce_wrap  out  1  one-cycle pulse when the nonce wraps 0xFFFFFFFF -> 0
- w_rq  in  1  hasher word request
- w_addr  in  5  requested word index
- w_data  out  32  word data; valid while w_rdy = 1
- w_rdy  out  1  one-cycle pulse; w_data valid

Behaviour:
- Clock is clk. Reset is asynchronous and active-high, port rst.
- Reset values: state IDLE, byte count 0, in_ready 0, hdr_valid 0, nonce_wrap 0, w_rdy 0, w_data 0. Header storage is not cleared.

States:
- IDLE: load_start -> LOAD.
- LOAD: in_ready = 1.
  - Each accepted byte n (0..HDR_BYTES-1) is stored at byte n.
  - Word k is {byte 4k, 4k+1, 4k+2, 4k+3}, with byte 4k in [31:24].
  - Count increments per accepted byte.
  - On acceptance of the last byte: -> READY, in_ready 0 next cycle, hdr_valid 1 next cycle.
- READY: hdr_valid = 1; serves word requests.
- load_start in any state: count = 0, hdr_valid 0, in_ready 1, next state LOAD. It overrides in_valid and nonce_inc in the same cycle (the byte is not taken).

Word serving (READY only):
- A request is accepted in a cycle with w_rq = 1 and w_rdy = 0.
- Next cycle: w_rdy = 1 and w_data = word(w_addr sampled at accept). Latency is exactly 1.
- While w_rdy = 1, no new accept occurs. Back-to-back service is therefore one word per 2 cycles, and the requester may hold w_rq high.
- In IDLE or LOAD, requests are not accepted: w_rdy stays 0 and the request waits.

Word map:
- addr < HDR_BYTES/4 (0..19): stored header word.
- addr 20: 0x80000000.
- addr 21..30: 0x00000000.
- addr 31: LEN_BITS (0x00000280).

Nonce:
- Value = {byte 79, 78, 77, 76} (little-endian within word 19).
- nonce_inc in READY: value + 1 mod 2^32, written back little-endian.
- Carry out: nonce_wrap pulses 1 cycle.
- nonce_inc outside READY: ignored.

Simultaneous events:
- A request accepted in the same cycle as nonce_inc returns the old nonce word.
- The new nonce is visible to accepts from the following cycle.
- Reset mid-load or mid-serve: immediate return to reset values; a pending w_rdy is dropped.

Decomposition:
- Package btc_pkg:
  - HDR_BYTES, NONCE_WORD, PAD_WORD (0x80000000), LEN_WORD (0x00000280).
  - State encoding S_IDLE/S_LOAD/S_READY.
  - Function byteswap32.
- Sub-module header_regfile: 20×32 storage with byte write port, word read port, and nonce read-modify-write port.
- Padding mux and FSM stay in header_word_server.

Test Plan:
- Load bytes 0x00..0x4F, then request addr 0, 19, 20, 25, 31 -> w_data 0x00010203, 0x4C4D4E4F, 0x80000000, 0x00000000, 0x00000280, each with w_rdy exactly 1 cycle after accept.
- With bytes 76..79 = FF FF FF FF, pulse nonce_inc -> nonce_wrap pulses; addr 19 reads 0x00000000.
- With bytes 76..79 = 01 00 00 00, pulse nonce_inc -> addr 19 reads 0x02000000.
- Hold w_rq = 1 with addr 0..31 stepping after each w_rdy -> 32 pulses at 2-cycle spacing; data matches the word map.
- w_rq asserted during LOAD -> no w_rdy until the cycle after the 80th byte plus accept; then correct data.
- load_start after 40 bytes, then 80 fresh bytes -> header reflects only the fresh bytes.
- Assert rst mid-load -> in_ready, hdr_valid and w_rdy are 0 in the same cycle.
- nonce_inc in the same cycle as an addr-19 accept -> old value returned; the next request returns the incremented value.
